// File: rtl/pipeline_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control field
// layout, per-stage control widths, the NOP control encoding and skid states.
package pipeline_pkg;

  // Control payload layout of the widest stage barrier (ID/EX).
  typedef struct packed {
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_fields_t;

  // Bit positions of the control fields inside the control payload.
  localparam int CTRL_ALU_OP_LSB     = 0;
  localparam int CTRL_ALU_OP_MSB     = 1;
  localparam int CTRL_ALU_SRC_BIT    = 2;
  localparam int CTRL_MEM_READ_BIT   = 3;
  localparam int CTRL_MEM_WRITE_BIT  = 4;
  localparam int CTRL_MEM_TO_REG_BIT = 5;
  localparam int CTRL_REG_WRITE_BIT  = 6;
  localparam int CTRL_BRANCH_BIT     = 7;

  // Control widths carried by each barrier; later stages drop consumed fields.
  localparam int CTRL_WIDTH_IF_ID  = 8;
  localparam int CTRL_WIDTH_ID_EX  = $bits(ctrl_fields_t);
  localparam int CTRL_WIDTH_EX_MEM = 5;
  localparam int CTRL_WIDTH_MEM_WB = 2;

  // All-zero control is a NOP: no register or memory write, no branch.
  localparam logic [7:0] PIPE_CTRL_BUBBLE = 8'h00;

  // Occupancy of a two-entry (skid) stage.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipeline_entry_reg.sv
// One pipeline entry: valid bit, control (reset/clear to bubble) and data
// (never reset). Clear takes priority over load.
module pipeline_entry_reg
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CTRL_WIDTH  = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CTRL_WIDTH-1:0] ctrl
);

  logic                  valid_q, valid_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-entry selection: clear empties to a bubble, load captures new payload.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid and control flops; reset forces an empty bubble immediately.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Data flops carry no reset; their value is meaningless while invalid.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// optional skid entry (registered inReady) and a saturating stall counter.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CTRL_WIDTH  = CTRL_WIDTH_ID_EX,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = CTRL_WIDTH'(PIPE_CTRL_BUBBLE),
  parameter bit                    SKID        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic [CTRL_WIDTH-1:0] inCtrl,
  input  logic                  flush,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [CTRL_WIDTH-1:0] outCtrl,
  output logic [15:0]           stallCount
);

  logic                  accept;
  logic                  out_xfer;
  logic                  main_load;
  logic                  main_clear;
  logic [DATA_WIDTH-1:0] main_in_data;
  logic [CTRL_WIDTH-1:0] main_in_ctrl;
  logic [15:0]           stall_count_q, stall_count_d;

  // A flushed cycle never accepts: the presented input is dropped.
  assign accept   = inValid && inReady && !flush;
  assign out_xfer = outValid && outReady;

  pipeline_entry_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH),
    .CTRL_BUBBLE(CTRL_BUBBLE)
  ) u_main (
    .clk    (clk),
    .rstN   (rstN),
    .load   (main_load),
    .clear  (main_clear),
    .in_data(main_in_data),
    .in_ctrl(main_in_ctrl),
    .valid  (outValid),
    .data   (outData),
    .ctrl   (outCtrl)
  );

  if (SKID == 1'b0) begin : g_single

    assign inReady = !outValid || outReady;

    // Single entry: load on accept, otherwise empty when the entry leaves.
    always_comb begin
      main_in_data = inData;
      main_in_ctrl = inCtrl;
      main_load    = accept;
      main_clear   = flush || (out_xfer && !accept);
    end

  end else begin : g_skid

    skid_state_e           state_q, state_d;
    logic                  skid_load;
    logic                  skid_clear;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;

    pipeline_entry_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH),
      .CTRL_BUBBLE(CTRL_BUBBLE)
    ) u_skid (
      .clk    (clk),
      .rstN   (rstN),
      .load   (skid_load),
      .clear  (skid_clear),
      .in_data(inData),
      .in_ctrl(inCtrl),
      .valid  (skid_valid),
      .data   (skid_data),
      .ctrl   (skid_ctrl)
    );

    // Occupancy state register.
    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        state_q <= SKID_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Ready depends only on the registered state, never on outReady.
    assign inReady = (state_q != SKID_FULL);

    // Occupancy transitions; the skid entry always drains into main first.
    always_comb begin
      state_d      = state_q;
      main_load    = 1'b0;
      main_clear   = 1'b0;
      main_in_data = inData;
      main_in_ctrl = inCtrl;
      skid_load    = 1'b0;
      skid_clear   = 1'b0;
      if (flush) begin
        state_d    = SKID_EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          SKID_EMPTY: begin
            if (accept) begin
              state_d   = SKID_BUSY;
              main_load = 1'b1;
            end else begin
              state_d = SKID_EMPTY;
            end
          end
          SKID_BUSY: begin
            if (accept && out_xfer) begin
              main_load = 1'b1;
            end else if (accept) begin
              state_d   = SKID_FULL;
              skid_load = 1'b1;
            end else if (out_xfer) begin
              state_d    = SKID_EMPTY;
              main_clear = 1'b1;
            end else begin
              state_d = SKID_BUSY;
            end
          end
          SKID_FULL: begin
            if (out_xfer) begin
              state_d      = SKID_BUSY;
              main_load    = skid_valid;
              main_in_data = skid_data;
              main_in_ctrl = skid_ctrl;
              skid_clear   = 1'b1;
            end else begin
              state_d = SKID_FULL;
            end
          end
          default: begin
            state_d    = SKID_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end

  end

  // Stall counter next value: count held-but-not-consumed cycles, saturate.
  always_comb begin
    stall_count_d = stall_count_q;
    if (outValid && !outReady && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: one SKID=0 and one SKID=1 instance, a
// per-instance scoreboard queue, a vector table for the SKID=1 corner cases,
// saturation of the stall counter and a random valid/ready/flush run.
module tb_pipeline_stage_reg;

  localparam logic [7:0] BUB = 8'h00;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [7:0]  c;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [7:0]  ec;
    logic        eir;
    logic [15:0] es;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        in_valid   [2];
  logic [31:0] in_data    [2];
  logic [7:0]  in_ctrl    [2];
  logic        flush      [2];
  logic        out_ready  [2];
  logic        in_ready_s [2];
  logic        out_valid_s[2];
  logic [31:0] out_data_s [2];
  logic [7:0]  out_ctrl_s [2];
  logic [15:0] stall_s    [2];

  logic [15:0] exp_stall[2];
  logic [39:0] sbq0[$];
  logic [39:0] sbq1[$];
  vec_t        vecs[$];
  int          checks;
  int          errors;

  pipeline_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CTRL_BUBBLE(BUB), .SKID(1'b0)) u_dut0 (
    .clk(clk), .rstN(rstN), .inValid(in_valid[0]), .inReady(in_ready_s[0]),
    .inData(in_data[0]), .inCtrl(in_ctrl[0]), .flush(flush[0]), .outValid(out_valid_s[0]),
    .outReady(out_ready[0]), .outData(out_data_s[0]), .outCtrl(out_ctrl_s[0]), .stallCount(stall_s[0])
  );

  pipeline_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CTRL_BUBBLE(BUB), .SKID(1'b1)) u_dut1 (
    .clk(clk), .rstN(rstN), .inValid(in_valid[1]), .inReady(in_ready_s[1]),
    .inData(in_data[1]), .inCtrl(in_ctrl[1]), .flush(flush[1]), .outValid(out_valid_s[1]),
    .outReady(out_ready[1]), .outData(out_data_s[1]), .outCtrl(out_ctrl_s[1]), .stallCount(stall_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ctl(input logic [31:0] d);
    return 8'h40 + d[7:0];
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [7:0] c,
                              input logic fl, input logic rdy, input logic ev,
                              input logic [31:0] ed, input logic eir, input logic [15:0] es);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.fl = fl; r.rdy = rdy;
    r.ev = ev; r.ed = ed; r.ec = ev ? ctl(ed) : BUB; r.eir = eir; r.es = es;
    return r;
  endfunction

  task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic fl, input logic rdy);
    in_valid[k] = v; in_data[k] = d; in_ctrl[k] = c; flush[k] = fl; out_ready[k] = rdy;
  endtask

  // Scoreboard step at the falling edge: compare, then account for the coming edge.
  task automatic sb_step(input int k);
    logic [39:0] q[$];
    logic [39:0] front;
    if (k == 0) q = sbq0; else q = sbq1;
    if (!rstN) begin
      q.delete();
      exp_stall[k] = 16'd0;
      check("rst_valid", k, 64'(out_valid_s[k]), 64'(1'b0));
      check("rst_ctrl", k, 64'(out_ctrl_s[k]), 64'(BUB));
      check("rst_stall", k, 64'(stall_s[k]), 64'(16'd0));
      check("rst_in_ready", k, 64'(in_ready_s[k]), 64'(1'b1));
    end else begin
      check("stall", k, 64'(stall_s[k]), 64'(exp_stall[k]));
      check("occupancy", k, 64'(out_valid_s[k]), 64'(q.size() != 0));
      if (!out_valid_s[k]) check("bubble", k, 64'(out_ctrl_s[k]), 64'(BUB));
      if (k == 1) check("in_ready", k, 64'(in_ready_s[k]), 64'(q.size() < 2));
      else        check("in_ready", k, 64'(in_ready_s[k]), 64'(!out_valid_s[k] || out_ready[k]));
      if (out_valid_s[k] && out_ready[k] && q.size() != 0) begin
        front = q.pop_front();
        check("out_entry", k, 64'({out_ctrl_s[k], out_data_s[k]}), 64'(front));
      end
      if (flush[k]) q.delete();
      else if (in_valid[k] && in_ready_s[k]) q.push_back({in_ctrl[k], in_data[k]});
      if (out_valid_s[k] && !out_ready[k] && exp_stall[k] != 16'hFFFF) exp_stall[k] = exp_stall[k] + 16'd1;
    end
    if (k == 0) sbq0 = q; else sbq1 = q;
  endtask

  // One clock: scoreboard at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    sb_step(0);
    sb_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        pv[2];
    logic [31:0] pd[2];
    logic [7:0]  pc[2];
    logic [15:0] ps[2];
    logic        pr;
    vec_t        cv;
    checks = 0;
    errors = 0;
    exp_stall[0] = 16'd0;
    exp_stall[1] = 16'd0;
    rstN = 1'b0;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b0, 1'b1);

    // Table: streaming, backpressure and flush expectations for the SKID=1 stage.
    vecs.push_back(mk(1'b1, 32'd1, ctl(32'd1), 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 16'd0));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(1'b1, 32'(k + 1), ctl(32'(k + 1)), 1'b0, 1'b1, 1'b1, 32'(k), 1'b1, 16'd0));
    vecs.push_back(mk(1'b0, 32'd0, BUB, 1'b0, 1'b1, 1'b1, 32'd8, 1'b1, 16'd0));
    vecs.push_back(mk(1'b0, 32'd0, BUB, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 32'd9,  ctl(32'd9),  1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 32'd10, ctl(32'd10), 1'b0, 1'b0, 1'b1, 32'd9,  1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 32'd11, ctl(32'd11), 1'b0, 1'b0, 1'b1, 32'd9,  1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 32'd11, ctl(32'd11), 1'b0, 1'b0, 1'b1, 32'd9,  1'b0, 16'd2));
    vecs.push_back(mk(1'b1, 32'd11, ctl(32'd11), 1'b0, 1'b1, 1'b1, 32'd9,  1'b0, 16'd3));
    vecs.push_back(mk(1'b1, 32'd11, ctl(32'd11), 1'b0, 1'b1, 1'b1, 32'd10, 1'b1, 16'd3));
    vecs.push_back(mk(1'b0, 32'd0,  BUB,         1'b0, 1'b1, 1'b1, 32'd11, 1'b1, 16'd3));
    vecs.push_back(mk(1'b0, 32'd0,  BUB,         1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 16'd3));
    vecs.push_back(mk(1'b1, 32'd20, ctl(32'd20), 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 16'd3));
    vecs.push_back(mk(1'b1, 32'd21, ctl(32'd21), 1'b0, 1'b0, 1'b1, 32'd20, 1'b1, 16'd3));
    vecs.push_back(mk(1'b1, 32'd22, 8'hFF,       1'b1, 1'b0, 1'b1, 32'd20, 1'b0, 16'd4));
    vecs.push_back(mk(1'b1, 32'd23, 8'hFF,       1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 16'd5));
    vecs.push_back(mk(1'b1, 32'd24, ctl(32'd24), 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 16'd5));
    vecs.push_back(mk(1'b0, 32'd0,  BUB,         1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 16'd5));
    vecs.push_back(mk(1'b0, 32'd0,  BUB,         1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 16'd5));

    // Power-on reset, then release one unit after a rising edge.
    repeat (3) cycle();
    rstN = 1'b1;

    // Mid-stream reset: fill both stages, then reset between edges.
    for (int k = 0; k < 2; k++) drive(k, 1'b1, 32'd100, ctl(32'd100), 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 2; k++) drive(k, 1'b1, 32'd101, ctl(32'd101), 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) check("pre_reset_valid", k, 64'(out_valid_s[k]), 64'(1'b1));
    #2 rstN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async_rst_valid", k, 64'(out_valid_s[k]), 64'(1'b0));
      check("async_rst_ctrl", k, 64'(out_ctrl_s[k]), 64'(BUB));
      check("async_rst_stall", k, 64'(stall_s[k]), 64'(16'd0));
    end
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b0, 1'b1);
    cycle();
    cycle();
    rstN = 1'b1;

    // Vector table: both instances see the stimulus, SKID=1 outputs checked per row.
    for (int i = 0; i < vecs.size(); i++) begin
      cv = vecs[i];
      for (int k = 0; k < 2; k++) drive(k, cv.v, cv.d, cv.c, cv.fl, cv.rdy);
      #1;
      check($sformatf("vec%0d_valid", i), 1, 64'(out_valid_s[1]), 64'(cv.ev));
      if (cv.ev) check($sformatf("vec%0d_data", i), 1, 64'(out_data_s[1]), 64'(cv.ed));
      check($sformatf("vec%0d_ctrl", i), 1, 64'(out_ctrl_s[1]), 64'(cv.ec));
      check($sformatf("vec%0d_in_ready", i), 1, 64'(in_ready_s[1]), 64'(cv.eir));
      check($sformatf("vec%0d_stall", i), 1, 64'(stall_s[1]), 64'(cv.es));
      cycle();
    end

    // Stall counter saturation: hold one entry with outReady low for 70000 cycles.
    for (int k = 0; k < 2; k++) drive(k, 1'b1, 32'd500, ctl(32'd500), 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b0, 1'b0);
    repeat (70000) cycle();
    for (int k = 0; k < 2; k++) check("stall_saturated", k, 64'(stall_s[k]), 64'(16'hFFFF));
    repeat (4) cycle();
    for (int k = 0; k < 2; k++) check("stall_holds", k, 64'(stall_s[k]), 64'(16'hFFFF));
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b1, 1'b0);
    cycle();
    for (int k = 0; k < 2; k++) check("flush_keeps_stall", k, 64'(stall_s[k]), 64'(16'hFFFF));

    // Reset again so the random run exercises the counter from zero.
    rstN = 1'b0;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b0, 1'b1);
    cycle();
    rstN = 1'b1;

    // Random valid/ready/flush; outputs must not move when inputs change mid-cycle.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 2; k++) begin
        pv[k] = out_valid_s[k]; pd[k] = out_data_s[k]; pc[k] = out_ctrl_s[k]; ps[k] = stall_s[k];
      end
      pr = in_ready_s[1];
      for (int k = 0; k < 2; k++)
        drive(k, $urandom_range(0, 99) < 70, $urandom, 8'($urandom),
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60);
      #1;
      for (int k = 0; k < 2; k++) begin
        check("comb_valid", k, 64'(out_valid_s[k]), 64'(pv[k]));
        check("comb_data", k, 64'(out_data_s[k]), 64'(pd[k]));
        check("comb_ctrl", k, 64'(out_ctrl_s[k]), 64'(pc[k]));
        check("comb_stall", k, 64'(stall_s[k]), 64'(ps[k]));
      end
      check("comb_in_ready", 1, 64'(in_ready_s[1]), 64'(pr));
      cycle();
    end

    // Drain and confirm both stages end empty.
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 32'd0, BUB, 1'b0, 1'b1);
    repeat (4) cycle();
    for (int k = 0; k < 2; k++) check("drained", k, 64'(out_valid_s[k]), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
